// File: rtl/paddle.sv
// Player paddle: debounced up/down buttons move the paddle once per frame at the
// start of vertical blank; the paddle is rendered as a registered 1-bit video term.
module paddle #(
  parameter int H_VISIBLE       = 640,
  parameter int V_VISIBLE       = 480,
  parameter int PADDLE_X        = 16,
  parameter int PADDLE_W        = 8,
  parameter int PADDLE_H        = 64,
  parameter int SPEED           = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Btn_Up,
  input  logic       i_Btn_Down,
  input  logic [9:0] i_HSync_Pos,
  input  logic [9:0] i_VSync_Pos,
  output logic [9:0] o_Paddle_Y,
  output logic       o_Video
);

  localparam int          CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [10:0] Y_MAX   = 11'(V_VISIBLE - PADDLE_H);
  localparam logic [9:0]  Y_RESET = 10'((V_VISIBLE - PADDLE_H) / 2);

  typedef enum logic [1:0] {
    MOVE_HOLD = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2
  } motion_e;

  // Bit 0 = up button, bit 1 = down button.
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            stable_q, stable_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]            y_q, y_d;
  logic                  video_q, video_d;
  motion_e               motion;
  logic                  tick;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] != stable_q[b]) begin
        if (cnt_q[b] == CNT_MAX) begin
          stable_d[b] = sync2_q[b];
          cnt_d[b]    = '0;
        end else begin
          cnt_d[b] = cnt_q[b] + 1'b1;
        end
      end else begin
        cnt_d[b] = '0;
      end
    end
  end

  assign tick = (i_HSync_Pos == 10'd0) && (i_VSync_Pos == 10'(V_VISIBLE));

  always_comb begin
    motion = MOVE_HOLD;
    if (stable_q[0] && !stable_q[1]) begin
      motion = MOVE_UP;
    end else if (stable_q[1] && !stable_q[0]) begin
      motion = MOVE_DOWN;
    end
  end

  // Down motion is summed in 11 bits so the clamp compare cannot see a wrapped value.
  logic [10:0] down_sum;
  assign down_sum = {1'b0, y_q} + 11'(SPEED);

  always_comb begin
    y_d = y_q;
    if (tick) begin
      unique case (motion)
        MOVE_UP:   y_d = (y_q < 10'(SPEED)) ? 10'd0 : y_q - 10'(SPEED);
        MOVE_DOWN: y_d = (down_sum > Y_MAX) ? Y_MAX[9:0] : down_sum[9:0];
        default:   y_d = y_q;
      endcase
    end
  end

  logic [10:0] h_ext, v_ext, y_ext;
  assign h_ext = {1'b0, i_HSync_Pos};
  assign v_ext = {1'b0, i_VSync_Pos};
  assign y_ext = {1'b0, y_q};

  always_comb begin
    video_d = (h_ext >= 11'(PADDLE_X)) && (h_ext < 11'(PADDLE_X + PADDLE_W)) &&
              (v_ext >= y_ext) && (v_ext < y_ext + 11'(PADDLE_H)) &&
              (h_ext < 11'(H_VISIBLE)) && (v_ext < 11'(V_VISIBLE));
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      y_q      <= Y_RESET;
      video_q  <= 1'b0;
    end else begin
      sync1_q  <= {i_Btn_Down, i_Btn_Up};
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      video_q  <= video_d;
    end
  end

  assign o_Paddle_Y = y_q;
  assign o_Video    = video_q;

endmodule

// File: tb/tb_paddle.sv
// Bench for paddle: directed button/position vectors, a frame-level reference model
// compared every cycle, and literal expectations at key points.
module tb_paddle;

  localparam int DB = 4;

  logic       i_Clk = 1'b0;
  logic       i_Reset;
  logic       i_Btn_Up;
  logic       i_Btn_Down;
  logic [9:0] i_HSync_Pos;
  logic [9:0] i_VSync_Pos;
  logic [9:0] o_Paddle_Y;
  logic       o_Video;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // Reference model state
  int m_y, m_video;
  int m_sync1[2], m_sync2[2], m_stable[2], m_run[2];

  paddle #(.DEBOUNCE_CYCLES(DB)) dut (
    .i_Clk       (i_Clk),
    .i_Reset     (i_Reset),
    .i_Btn_Up    (i_Btn_Up),
    .i_Btn_Down  (i_Btn_Down),
    .i_HSync_Pos (i_HSync_Pos),
    .i_VSync_Pos (i_VSync_Pos),
    .o_Paddle_Y  (o_Paddle_Y),
    .o_Video     (o_Video)
  );

  always #5 i_Clk = ~i_Clk;

  function automatic int video_fn(int h, int v, int y);
    return (h >= 16 && h < 24 && v >= y && v < y + 64 && h < 640 && v < 480) ? 1 : 0;
  endfunction

  function automatic int motion_fn(int h, int v, int y, int up, int down);
    if (!(h == 0 && v == 480)) return y;
    if (up == 1 && down == 0) return (y < 4) ? 0 : y - 4;
    if (down == 1 && up == 0) return (y + 4 > 416) ? 416 : y + 4;
    return y;
  endfunction

  always @(posedge i_Clk) begin
    if (i_Reset) begin
      m_y     <= 208;
      m_video <= 0;
      for (int b = 0; b < 2; b++) begin
        m_sync1[b]  <= 0;
        m_sync2[b]  <= 0;
        m_stable[b] <= 0;
        m_run[b]    <= 0;
      end
    end else begin
      m_video <= video_fn(int'(i_HSync_Pos), int'(i_VSync_Pos), m_y);
      m_y     <= motion_fn(int'(i_HSync_Pos), int'(i_VSync_Pos), m_y, m_stable[0], m_stable[1]);
      m_sync1[0] <= int'(i_Btn_Up);
      m_sync1[1] <= int'(i_Btn_Down);
      for (int b = 0; b < 2; b++) begin
        m_sync2[b] <= m_sync1[b];
        if (m_sync2[b] != m_stable[b]) begin
          if (m_run[b] + 1 == DB) begin
            m_stable[b] <= m_sync2[b];
            m_run[b]    <= 0;
          end else begin
            m_run[b] <= m_run[b] + 1;
          end
        end else begin
          m_run[b] <= 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge i_Clk) begin
    if (cmp_en) begin
      check("model_y", {1'b0, o_Paddle_Y}, 11'(m_y));
      check("model_video", {10'd0, o_Video}, 11'(m_video));
    end
  end

  task automatic clk_n(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  task automatic set_pos(input int h, input int v);
    i_HSync_Pos = 10'(h);
    i_VSync_Pos = 10'(v);
  endtask

  task automatic set_btn(input logic up, input logic down);
    i_Btn_Up   = up;
    i_Btn_Down = down;
    clk_n(8);
  endtask

  task automatic frame_tick();
    set_pos(0, 480);
    clk_n(1);
    set_pos(100, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) frame_tick();
  endtask

  task automatic pixel(input int h, input int v, input logic exp, input string name);
    set_pos(h, v);
    clk_n(1);
    check(name, {10'd0, o_Video}, {10'd0, exp});
    set_pos(100, 0);
  endtask

  initial begin
    i_Reset    = 1'b1;
    i_Btn_Up   = 1'b0;
    i_Btn_Down = 1'b0;
    set_pos(100, 0);
    repeat (3) @(posedge i_Clk);
    @(negedge i_Clk);
    i_Reset = 1'b0;
    check("reset_y", {1'b0, o_Paddle_Y}, 11'd208);
    check("reset_video", {10'd0, o_Video}, 11'd0);
    cmp_en = 1'b1;

    // Short glitch must not register as a press
    i_Btn_Up = 1'b1;
    clk_n(3);
    i_Btn_Up = 1'b0;
    clk_n(10);
    ticks(2);
    check("glitch_y", {1'b0, o_Paddle_Y}, 11'd208);

    // Stable level appears 6 edges after the press: tick on edge 6 still holds
    i_Btn_Up = 1'b1;
    clk_n(5);
    frame_tick();
    check("debounce_edge6_hold", {1'b0, o_Paddle_Y}, 11'd208);
    frame_tick();
    check("debounce_edge7_move", {1'b0, o_Paddle_Y}, 11'd204);
    ticks(4);
    check("up_5_frames", {1'b0, o_Paddle_Y}, 11'd188);

    set_btn(1'b1, 1'b1);
    ticks(2);
    check("both_hold", {1'b0, o_Paddle_Y}, 11'd188);

    set_btn(1'b1, 1'b0);
    ticks(47);
    check("top_reach", {1'b0, o_Paddle_Y}, 11'd0);
    ticks(2);
    check("top_clamp", {1'b0, o_Paddle_Y}, 11'd0);

    set_btn(1'b0, 1'b1);
    ticks(104);
    check("bottom_reach", {1'b0, o_Paddle_Y}, 11'd416);
    ticks(2);
    check("bottom_clamp", {1'b0, o_Paddle_Y}, 11'd416);

    set_btn(1'b1, 1'b0);
    ticks(52);
    set_btn(1'b0, 1'b0);
    check("back_to_208", {1'b0, o_Paddle_Y}, 11'd208);

    pixel(16, 208, 1'b1, "video_16_208");
    pixel(23, 271, 1'b1, "video_23_271");
    pixel(24, 208, 1'b0, "video_24_208");
    pixel(16, 272, 1'b0, "video_16_272");
    pixel(15, 240, 1'b0, "video_15_240");
    pixel(16, 207, 1'b0, "video_16_207");

    // Only (0,480) is a tick
    set_btn(1'b0, 1'b1);
    set_pos(0, 479);
    clk_n(1);
    check("no_tick_479", {1'b0, o_Paddle_Y}, 11'd208);
    set_pos(0, 480);
    clk_n(1);
    check("tick_480", {1'b0, o_Paddle_Y}, 11'd212);
    set_pos(100, 0);

    set_btn(1'b1, 1'b0);
    ticks(28);
    check("y_100", {1'b0, o_Paddle_Y}, 11'd100);

    // Mid-frame reset while the paddle is drawn
    set_pos(20, 120);
    clk_n(1);
    check("video_before_reset", {10'd0, o_Video}, 11'd1);
    i_Reset = 1'b1;
    clk_n(1);
    check("midframe_reset_y", {1'b0, o_Paddle_Y}, 11'd208);
    check("midframe_reset_video", {10'd0, o_Video}, 11'd0);
    i_Reset = 1'b0;
    set_pos(100, 0);
    i_Btn_Up = 1'b0;
    clk_n(10);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
